// File: rtl/frame_ctrl.sv
// Frame buffer sequencer: fills a DEPTH-byte frame from SPI RX, hands it to the
// processing engine, then drains it to SPI TX, with sticky error tracking.
//
// state | meaning
// IDLE  | pointers cleared, waiting for ssel low
// FILL  | writing received bytes at wr_ptr
// PROC  | engine owns the buffer, timeout timer running
// SEND  | transmitter armed, reading at rd_ptr
// DONE  | frame complete, count and pulse frame_done
module frame_ctrl #(
  parameter int DEPTH   = 64,
  parameter int AW      = 6,
  parameter int DW      = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_ssel,
  input  logic          i_rx_valid,
  input  logic [DW-1:0] i_rx_data,
  input  logic          i_proc_done,
  input  logic          i_tx_req,
  input  logic          i_err_clr,
  output logic          o_buf_we,
  output logic [AW-1:0] o_buf_waddr,
  output logic [DW-1:0] o_buf_wdata,
  output logic [AW-1:0] o_buf_raddr,
  output logic          o_proc_start,
  output logic          o_tx_arm,
  output logic          o_busy,
  output logic          o_frame_done,
  output logic [7:0]    o_frame_count,
  output logic          o_err_short,
  output logic          o_err_overrun,
  output logic          o_err_timeout
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_PROC, S_SEND, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_wr_ptr, w_wr_ptr_nxt;
  logic [AW-1:0] r_rd_ptr, w_rd_ptr_nxt;
  logic [TW-1:0] r_tmr, w_tmr_nxt;

  logic          r_buf_we, w_buf_we;
  logic [AW-1:0] r_buf_waddr, w_buf_waddr;
  logic [DW-1:0] r_buf_wdata, w_buf_wdata;
  logic          r_proc_start, w_proc_start;
  logic          r_tx_arm, w_tx_arm;
  logic          r_busy, w_busy;
  logic          r_frame_done, w_frame_done;
  logic [7:0]    r_frame_count;
  logic          r_err_short, w_set_short;
  logic          r_err_overrun, w_set_overrun;
  logic          r_err_timeout, w_set_timeout;

  logic w_last_wr, w_last_rd, w_tmr_tc;

  assign w_last_wr = (r_wr_ptr == AW'(DEPTH - 1));
  assign w_last_rd = (r_rd_ptr == AW'(DEPTH - 1));
  assign w_tmr_tc  = (r_tmr == '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_tmr         <= '0;
      r_buf_we      <= 1'b0;
      r_buf_waddr   <= '0;
      r_buf_wdata   <= '0;
      r_proc_start  <= 1'b0;
      r_tx_arm      <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_count <= '0;
      r_err_short   <= 1'b0;
      r_err_overrun <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_wr_ptr     <= w_wr_ptr_nxt;
      r_rd_ptr     <= w_rd_ptr_nxt;
      r_tmr        <= w_tmr_nxt;
      r_buf_we     <= w_buf_we;
      r_buf_waddr  <= w_buf_waddr;
      r_buf_wdata  <= w_buf_wdata;
      r_proc_start <= w_proc_start;
      r_tx_arm     <= w_tx_arm;
      r_busy       <= w_busy;
      r_frame_done <= w_frame_done;
      if (w_frame_done) r_frame_count <= r_frame_count + 8'd1;
      // err_clr wins over any error raised in the same cycle
      if (i_err_clr) begin
        r_err_short   <= 1'b0;
        r_err_overrun <= 1'b0;
        r_err_timeout <= 1'b0;
      end else begin
        r_err_short   <= r_err_short   | w_set_short;
        r_err_overrun <= r_err_overrun | w_set_overrun;
        r_err_timeout <= r_err_timeout | w_set_timeout;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (!i_ssel) w_state_nxt = S_FILL;
      S_FILL: begin
        if (i_rx_valid && w_last_wr) w_state_nxt = S_PROC;
        else if (i_ssel)             w_state_nxt = S_IDLE;
      end
      S_PROC: begin
        if (i_proc_done)   w_state_nxt = S_SEND;
        else if (w_tmr_tc) w_state_nxt = S_IDLE;
      end
      S_SEND: if (i_tx_req && w_last_rd) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_wr_ptr_nxt  = r_wr_ptr;
    w_rd_ptr_nxt  = r_rd_ptr;
    w_tmr_nxt     = r_tmr;
    w_buf_we      = 1'b0;
    w_buf_waddr   = r_buf_waddr;
    w_buf_wdata   = r_buf_wdata;
    w_proc_start  = 1'b0;
    w_set_short   = 1'b0;
    w_set_overrun = 1'b0;
    w_set_timeout = 1'b0;
    case (r_state)
      S_IDLE: w_set_overrun = i_rx_valid && !i_ssel;
      S_FILL: begin
        // timer is preloaded so the first PROC cycle sees the full count
        w_tmr_nxt = TW'(TIMEOUT);
        if (i_rx_valid) begin
          w_buf_we    = 1'b1;
          w_buf_waddr = r_wr_ptr;
          w_buf_wdata = i_rx_data;
          if (!w_last_wr) w_wr_ptr_nxt = r_wr_ptr + 1'b1;
        end
        w_set_short = i_ssel && !(i_rx_valid && w_last_wr) &&
                      (i_rx_valid || (r_wr_ptr != '0));
      end
      S_PROC: begin
        w_proc_start  = (r_tmr == TW'(TIMEOUT));
        w_set_overrun = i_rx_valid && !i_ssel;
        w_set_timeout = w_tmr_tc && !i_proc_done;
        if (!w_tmr_tc)   w_tmr_nxt = r_tmr - 1'b1;
        if (i_proc_done) w_rd_ptr_nxt = '0;
      end
      S_SEND: begin
        w_set_overrun = i_rx_valid && !i_ssel;
        if (i_tx_req && !w_last_rd) w_rd_ptr_nxt = r_rd_ptr + 1'b1;
      end
      S_DONE: w_set_overrun = i_rx_valid && !i_ssel;
      default: ;
    endcase
    if (w_state_nxt == S_IDLE) begin
      w_wr_ptr_nxt = '0;
      w_rd_ptr_nxt = '0;
    end
  end

  assign w_tx_arm     = (w_state_nxt == S_SEND);
  assign w_busy       = (w_state_nxt != S_IDLE);
  assign w_frame_done = (r_state == S_SEND) && (w_state_nxt == S_DONE);

  assign o_buf_we      = r_buf_we;
  assign o_buf_waddr   = r_buf_waddr;
  assign o_buf_wdata   = r_buf_wdata;
  assign o_buf_raddr   = r_rd_ptr;
  assign o_proc_start  = r_proc_start;
  assign o_tx_arm      = r_tx_arm;
  assign o_busy        = r_busy;
  assign o_frame_done  = r_frame_done;
  assign o_frame_count = r_frame_count;
  assign o_err_short   = r_err_short;
  assign o_err_overrun = r_err_overrun;
  assign o_err_timeout = r_err_timeout;

endmodule
